// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order commit buffer, one alloc and two retires per cycle
module reorder_buffer #(
  parameter int NUM_REG       = 32,
  parameter int NUM_REG_LOG2  = $clog2(NUM_REG),
  parameter int NUM_TAGS      = 64,
  parameter int NUM_TAGS_LOG2 = $clog2(NUM_TAGS),
  parameter int ROB_DEPTH     = 16,
  parameter int ROB_IDX_W     = $clog2(ROB_DEPTH)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               alloc_valid,
  input  logic [NUM_TAGS_LOG2-1:0]           alloc_tag,
  input  logic [NUM_REG_LOG2-1:0]            alloc_reg,
  output logic                               alloc_ready,
  output logic [ROB_IDX_W-1:0]               alloc_idx,
  input  logic [1:0]                         complete_valid,
  input  logic [1:0][ROB_IDX_W-1:0]          complete_idx,
  output logic [1:0]                         retire_valid,
  output logic [1:0][NUM_TAGS_LOG2-1:0]      retire_tag,
  output logic [1:0][NUM_REG_LOG2-1:0]       retire_reg,
  output logic [ROB_IDX_W:0]                 count,
  output logic                               empty
);

  localparam int PTR_W = ROB_IDX_W + 1;
  localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(ROB_DEPTH);

  logic [ROB_DEPTH-1:0]                      valid_q, valid_d;
  logic [ROB_DEPTH-1:0]                      done_q, done_d;
  logic [ROB_DEPTH-1:0][NUM_TAGS_LOG2-1:0]   tag_q, tag_d;
  logic [ROB_DEPTH-1:0][NUM_REG_LOG2-1:0]    reg_q, reg_d;
  logic [PTR_W-1:0]                          head_q, head_d;
  logic [PTR_W-1:0]                          tail_q, tail_d;
  logic [PTR_W-1:0]                          count_q, count_d;
  logic [1:0]                                retire_valid_q, retire_valid_d;
  logic [1:0][NUM_TAGS_LOG2-1:0]             retire_tag_q, retire_tag_d;
  logic [1:0][NUM_REG_LOG2-1:0]              retire_reg_q, retire_reg_d;

  logic [ROB_IDX_W-1:0] head_idx, head1_idx, tail_idx;
  logic                 r0, r1, alloc_fire;

  assign head_idx    = head_q[ROB_IDX_W-1:0];
  assign head1_idx   = head_idx + ROB_IDX_W'(1);
  assign tail_idx    = tail_q[ROB_IDX_W-1:0];

  // Retire selection looks only at registered state; lane 1 never passes an unfinished lane 0
  assign r0          = valid_q[head_idx] & done_q[head_idx];
  assign r1          = r0 & valid_q[head1_idx] & done_q[head1_idx];

  // Room is judged from the registered count so a same-cycle retire cannot open a slot
  assign alloc_ready = (count_q < DEPTH_C);
  assign alloc_fire  = alloc_valid & alloc_ready;
  assign alloc_idx   = tail_idx;

  assign retire_valid = retire_valid_q;
  assign retire_tag   = retire_tag_q;
  assign retire_reg   = retire_reg_q;
  assign count        = count_q;
  assign empty        = (count_q == '0);

  // Next state: completions mark done, retires free the head, allocation fills the tail
  always_comb begin
    valid_d        = valid_q;
    done_d         = done_q;
    tag_d          = tag_q;
    reg_d          = reg_q;
    retire_valid_d = 2'b00;
    retire_tag_d   = '0;
    retire_reg_d   = '0;

    // Only entries already resident may complete; an entry being written this cycle is not yet valid
    for (int i = 0; i < 2; i++) begin
      if (complete_valid[i] && valid_q[complete_idx[i]]) begin
        done_d[complete_idx[i]] = 1'b1;
      end
    end

    if (r0) begin
      retire_valid_d[0] = 1'b1;
      retire_tag_d[0]   = tag_q[head_idx];
      retire_reg_d[0]   = reg_q[head_idx];
      valid_d[head_idx] = 1'b0;
      done_d[head_idx]  = 1'b0;
      tag_d[head_idx]   = '0;
      reg_d[head_idx]   = '0;
    end

    if (r1) begin
      retire_valid_d[1]  = 1'b1;
      retire_tag_d[1]    = tag_q[head1_idx];
      retire_reg_d[1]    = reg_q[head1_idx];
      valid_d[head1_idx] = 1'b0;
      done_d[head1_idx]  = 1'b0;
      tag_d[head1_idx]   = '0;
      reg_d[head1_idx]   = '0;
    end

    // Tail slot is never the retiring head here: alloc is blocked whenever the buffer is full
    if (alloc_fire) begin
      valid_d[tail_idx] = 1'b1;
      done_d[tail_idx]  = 1'b0;
      tag_d[tail_idx]   = alloc_tag;
      reg_d[tail_idx]   = alloc_reg;
    end

    head_d  = head_q + PTR_W'(r0) + PTR_W'(r1);
    tail_d  = tail_q + PTR_W'(alloc_fire);
    count_d = count_q + PTR_W'(alloc_fire) - PTR_W'(r0) - PTR_W'(r1);
  end

  // State register; reset discards every entry at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q        <= '0;
      done_q         <= '0;
      tag_q          <= '0;
      reg_q          <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      retire_valid_q <= 2'b00;
      retire_tag_q   <= '0;
      retire_reg_q   <= '0;
    end else begin
      valid_q        <= valid_d;
      done_q         <= done_d;
      tag_q          <= tag_d;
      reg_q          <= reg_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      retire_valid_q <= retire_valid_d;
      retire_tag_q   <= retire_tag_d;
      retire_reg_q   <= retire_reg_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed self-checking bench for reorder_buffer
module tb_reorder_buffer;

  logic            clk;
  logic            rst_n;
  logic            alloc_valid;
  logic [5:0]      alloc_tag;
  logic [4:0]      alloc_reg;
  logic            alloc_ready;
  logic [3:0]      alloc_idx;
  logic [1:0]      complete_valid;
  logic [1:0][3:0] complete_idx;
  logic [1:0]      retire_valid;
  logic [1:0][5:0] retire_tag;
  logic [1:0][4:0] retire_reg;
  logic [4:0]      count;
  logic            empty;

  int checks = 0;
  int errors = 0;
  int bad_lane = 0;
  int ret_q[$];
  int exp_q[$];

  reorder_buffer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alloc_valid    (alloc_valid),
    .alloc_tag      (alloc_tag),
    .alloc_reg      (alloc_reg),
    .alloc_ready    (alloc_ready),
    .alloc_idx      (alloc_idx),
    .complete_valid (complete_valid),
    .complete_idx   (complete_idx),
    .retire_valid   (retire_valid),
    .retire_tag     (retire_tag),
    .retire_reg     (retire_reg),
    .count          (count),
    .empty          (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record retired tags in order, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (retire_valid == 2'b10) bad_lane++;
      if (retire_valid[0]) ret_q.push_back(int'(retire_tag[0]));
      if (retire_valid[1]) ret_q.push_back(int'(retire_tag[1]));
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ret_q.delete();
    bad_lane = 0;
  endtask

  initial begin
    rst_n          = 1'b0;
    alloc_valid    = 1'b0;
    alloc_tag      = '0;
    alloc_reg      = '0;
    complete_valid = 2'b00;
    complete_idx   = '0;
    #2;
    chk("rst_alloc_ready", 32'(alloc_ready), 1);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_retire_valid", 32'(retire_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_alloc_idx", 32'(alloc_idx), 0);
    chk("rst_retire_tag", 32'(retire_tag), 0);
    chk("rst_retire_reg", 32'(retire_reg), 0);
    tick();
    tick();
    rst_n = 1'b1;

    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_alloc_ready", 32'(alloc_ready), 1);
      chk("idle_empty", 32'(empty), 1);
      chk("idle_retire_valid", 32'(retire_valid), 0);
      chk("idle_count", 32'(count), 0);
    end

    // Reset while entries are resident and a retire is on the outputs
    for (int i = 0; i < 7; i++) begin
      alloc_valid = 1'b1;
      alloc_tag   = 6'(i + 1);
      alloc_reg   = 5'(i);
      tick();
    end
    alloc_valid = 1'b0;
    chk("mid_count7", 32'(count), 7);
    complete_valid  = 2'b11;
    complete_idx[0] = 4'd0;
    complete_idx[1] = 4'd1;
    tick();
    complete_valid = 2'b00;
    tick();
    chk("mid_rv_before", 32'(retire_valid), 3);
    chk("mid_count5", 32'(count), 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rv", 32'(retire_valid), 0);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_tag", 32'(retire_tag), 0);
    chk("mid_rst_ready", 32'(alloc_ready), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single alloc, complete two cycles later, retire two edges after completion
    alloc_valid = 1'b1;
    alloc_tag   = 6'd33;
    alloc_reg   = 5'd5;
    chk("single_alloc_idx", 32'(alloc_idx), 0);
    tick();
    alloc_valid = 1'b0;
    chk("single_count1", 32'(count), 1);
    tick();
    complete_valid  = 2'b01;
    complete_idx[0] = 4'd0;
    tick();
    complete_valid = 2'b00;
    chk("single_rv_n", 32'(retire_valid), 0);
    tick();
    chk("single_rv", 32'(retire_valid), 1);
    chk("single_tag", 32'(retire_tag[0]), 33);
    chk("single_reg", 32'(retire_reg[0]), 5);
    chk("single_count0", 32'(count), 0);
    chk("single_empty", 32'(empty), 1);
    tick();
    chk("single_rv_after", 32'(retire_valid), 0);
    chk("single_tag_after", 32'(retire_tag), 0);

    // Out-of-order completion, in-order dual retire
    do_reset();
    for (int i = 0; i < 4; i++) begin
      alloc_valid = 1'b1;
      alloc_tag   = 6'(40 + i);
      alloc_reg   = 5'(10 + i);
      chk("ooo_alloc_idx", 32'(alloc_idx), i);
      tick();
    end
    alloc_valid     = 1'b0;
    chk("ooo_count4", 32'(count), 4);
    complete_valid  = 2'b11;
    complete_idx[0] = 4'd3;
    complete_idx[1] = 4'd2;
    tick();
    complete_valid  = 2'b01;
    complete_idx[0] = 4'd1;
    tick();
    complete_valid  = 2'b00;
    tick();
    tick();
    chk("ooo_no_retire", 32'(retire_valid), 0);
    chk("ooo_count_hold", 32'(count), 4);
    complete_valid  = 2'b01;
    complete_idx[0] = 4'd0;
    tick();
    complete_valid = 2'b00;
    chk("ooo_rv_n", 32'(retire_valid), 0);
    tick();
    chk("ooo_rv_k", 32'(retire_valid), 3);
    chk("ooo_tag0_k", 32'(retire_tag[0]), 40);
    chk("ooo_tag1_k", 32'(retire_tag[1]), 41);
    chk("ooo_reg0_k", 32'(retire_reg[0]), 10);
    chk("ooo_reg1_k", 32'(retire_reg[1]), 11);
    tick();
    chk("ooo_rv_k1", 32'(retire_valid), 3);
    chk("ooo_tag0_k1", 32'(retire_tag[0]), 42);
    chk("ooo_tag1_k1", 32'(retire_tag[1]), 43);
    chk("ooo_count0", 32'(count), 0);
    tick();
    chk("ooo_rv_end", 32'(retire_valid), 0);

    // Fill to full, blocked alloc, free one slot, alloc wraps to index 0
    do_reset();
    for (int i = 0; i < 16; i++) begin
      alloc_valid = 1'b1;
      alloc_tag   = 6'(20 + i);
      alloc_reg   = 5'(i);
      tick();
    end
    chk("full_count", 32'(count), 16);
    chk("full_ready", 32'(alloc_ready), 0);
    chk("full_alloc_idx", 32'(alloc_idx), 0);
    alloc_tag = 6'd63;
    alloc_reg = 5'd31;
    tick();
    chk("full_ignored_count", 32'(count), 16);
    alloc_tag       = 6'd50;
    alloc_reg       = 5'd7;
    complete_valid  = 2'b01;
    complete_idx[0] = 4'd0;
    tick();
    complete_valid = 2'b00;
    chk("full_count_n", 32'(count), 16);
    chk("full_ready_n", 32'(alloc_ready), 0);
    tick();
    chk("full_rv", 32'(retire_valid), 1);
    chk("full_rtag", 32'(retire_tag[0]), 20);
    chk("full_count15", 32'(count), 15);
    chk("full_ready_again", 32'(alloc_ready), 1);
    chk("full_wrap_idx", 32'(alloc_idx), 0);
    chk("full_tail_wrap", 32'(dut.tail_q), 16);
    tick();
    alloc_valid = 1'b0;
    chk("full_refill_count", 32'(count), 16);
    chk("full_refill_ready", 32'(alloc_ready), 0);
    chk("full_refill_tail", 32'(dut.tail_q), 17);
    for (int p = 0; p < 8; p++) begin
      complete_valid  = 2'b11;
      complete_idx[0] = 4'(2 * p + 1);
      complete_idx[1] = 4'((2 * p + 2) % 16);
      tick();
    end
    complete_valid = 2'b00;
    repeat (6) tick();
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(20 + i);
    exp_q.push_back(50);
    chk("full_ret_size", ret_q.size(), 17);
    for (int i = 0; i < 17; i++) begin
      if (i < ret_q.size()) chk("full_ret_order", ret_q[i], exp_q[i]);
    end
    chk("full_drain_count", 32'(count), 0);
    chk("full_bad_lane", bad_lane, 0);

    // Steady stream: alloc every cycle, complete three cycles later
    do_reset();
    for (int t = 0; t < 46; t++) begin
      alloc_valid = (t < 40);
      alloc_tag   = 6'(10 + t);
      alloc_reg   = 5'(t % 32);
      if (t >= 3 && t < 43) begin
        complete_valid  = 2'b01;
        complete_idx[0] = 4'((t - 3) % 16);
      end else begin
        complete_valid = 2'b00;
      end
      tick();
    end
    alloc_valid    = 1'b0;
    complete_valid = 2'b00;
    repeat (3) tick();
    chk("stream_size", ret_q.size(), 40);
    for (int i = 0; i < 40; i++) begin
      if (i < ret_q.size()) chk("stream_order", ret_q[i], 10 + i);
    end
    chk("stream_count", 32'(count), 0);
    chk("stream_head", 32'(dut.head_q), 8);
    chk("stream_tail", 32'(dut.tail_q), 8);
    chk("stream_bad_lane", bad_lane, 0);

    // Completion to an empty slot, then a tag-0 entry retiring normally
    do_reset();
    alloc_valid = 1'b1;
    alloc_tag   = 6'd7;
    alloc_reg   = 5'd1;
    tick();
    alloc_tag   = 6'd8;
    alloc_reg   = 5'd2;
    tick();
    alloc_valid     = 1'b0;
    complete_valid  = 2'b01;
    complete_idx[0] = 4'd9;
    tick();
    complete_valid = 2'b00;
    chk("stray_done9", 32'(dut.done_q[9]), 0);
    chk("stray_valid9", 32'(dut.valid_q[9]), 0);
    chk("stray_count", 32'(count), 2);
    tick();
    chk("stray_rv", 32'(retire_valid), 0);
    chk("stray_count2", 32'(count), 2);
    alloc_valid = 1'b1;
    alloc_tag   = 6'd0;
    alloc_reg   = 5'd0;
    chk("zero_alloc_idx", 32'(alloc_idx), 2);
    tick();
    alloc_valid     = 1'b0;
    complete_valid  = 2'b11;
    complete_idx[0] = 4'd0;
    complete_idx[1] = 4'd1;
    tick();
    complete_valid  = 2'b01;
    complete_idx[0] = 4'd2;
    tick();
    complete_valid = 2'b00;
    chk("zero_rv_pair", 32'(retire_valid), 3);
    chk("zero_tag_pair0", 32'(retire_tag[0]), 7);
    chk("zero_tag_pair1", 32'(retire_tag[1]), 8);
    tick();
    chk("zero_rv", 32'(retire_valid), 1);
    chk("zero_tag", 32'(retire_tag[0]), 0);
    chk("zero_reg", 32'(retire_reg[0]), 0);
    chk("zero_count", 32'(count), 0);
    chk("zero_empty", 32'(empty), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
